// File: rtl/morse_target_picker_pkg.sv
// Shared definitions for the Morse target picker: state encoding,
// default parameter values and the fallback index helper.
package morse_target_picker_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int NUM_SYMBOLS_DEF = 10;
   localparam int MAX_TRIES_DEF   = 8;

   // Successor of the previous target, wrapping at the symbol count.
   // last is always below num, so a single compare replaces the modulo.
   function automatic logic [3:0] next_index(input logic [3:0] last,
                                             input logic [4:0] num);
      logic [4:0] sum;
      sum = {1'b0, last} + 5'd1;
      if (sum >= num) begin
         return 4'd0;
      end
      return sum[3:0];
   endfunction

endpackage

// File: rtl/morse_target_picker.sv
// Morse target picker: draws a symbol index from an external LFSR value,
// retrying out-of-range draws and falling back to a deterministic successor
// of the previous target after MAX_TRIES attempts. The target is held until
// the consumer acknowledges it.
//
// Optional build macro: MORSE_NO_REPEAT_EN -- when defined, a draw equal to
// the previously delivered target is rejected like an out-of-range draw.
//
// state | meaning
// IDLE  | waiting for start
// DRAW  | sampling rnd once per cycle until accepted or tries exhausted
// HOLD  | target/valid/fallback frozen until ack
module morse_target_picker
   import morse_target_picker_pkg::*;
#(
   parameter int NUM_SYMBOLS = NUM_SYMBOLS_DEF,
   parameter int MAX_TRIES   = MAX_TRIES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] rnd,
   input  logic       ack,
   output logic [3:0] target,
   output logic       valid,
   output logic       busy,
   output logic       fallback
);

   localparam logic [4:0] C_NUM      = 5'(NUM_SYMBOLS);
   localparam logic [3:0] C_LAST_TRY = 4'(MAX_TRIES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_try_cnt;
   logic [3:0] r_target;
   logic [3:0] r_last_target;
   logic       r_valid;
   logic       r_fallback;
   logic       r_have_last;
   logic       w_in_range;
   logic       w_accept;
   logic       w_last_try;

   // 5-bit compare so that NUM_SYMBOLS=16 accepts every 4-bit value
   assign w_in_range = ({1'b0, rnd} < C_NUM);

`ifdef MORSE_NO_REPEAT_EN
   assign w_accept = w_in_range && (!r_have_last || (rnd != r_last_target));
`else
   assign w_accept = w_in_range;
`endif

   assign w_last_try = (r_try_cnt == C_LAST_TRY);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; start only matters in IDLE, ack only in HOLD
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (start) w_state_nxt = DRAW;
         DRAW: if (w_accept || w_last_try) w_state_nxt = HOLD;
         HOLD: if (ack) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Target, try counter and history registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_try_cnt     <= 4'd0;
         r_target      <= 4'd0;
         r_valid       <= 1'b0;
         r_fallback    <= 1'b0;
         r_last_target <= 4'd0;
         r_have_last   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_try_cnt <= 4'd0;
               end
            end
            DRAW: begin
               if (w_accept) begin
                  r_target   <= rnd;
                  r_fallback <= 1'b0;
                  r_valid    <= 1'b1;
               end else if (w_last_try) begin
                  r_target   <= r_have_last ? next_index(r_last_target, C_NUM) : 4'd0;
                  r_fallback <= 1'b1;
                  r_valid    <= 1'b1;
               end else begin
                  // never reaches past MAX_TRIES-1, so no wrap is possible
                  r_try_cnt <= r_try_cnt + 4'd1;
               end
            end
            HOLD: begin
               if (ack) begin
                  r_valid       <= 1'b0;
                  r_last_target <= r_target;
                  r_have_last   <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output decode
   always_comb begin
      busy     = (r_state != IDLE);
      target   = r_target;
      valid    = r_valid;
      fallback = r_fallback;
   end

endmodule

// File: tb/tb_morse_target_picker.sv
// Bench for morse_target_picker: a request-level model checked every cycle
// against the default-parameter instance, plus directed literal checks,
// and two extra instances for NUM_SYMBOLS=16 and MAX_TRIES=1.
module tb_morse_target_picker;

   localparam int NUM = 10;
   localparam int MAX = 8;

   logic       clk;
   logic       rst;
   logic       start, ack;
   logic [3:0] rnd;
   logic [3:0] target;
   logic       valid, busy, fallback;

   logic       e_start, e_ack;
   logic [3:0] e_rnd;
   logic [3:0] t16, t1;
   logic       v16, b16, f16, v1, b1, f1;

   int n_cmp = 0;
   int n_err = 0;

   morse_target_picker #(.NUM_SYMBOLS(NUM), .MAX_TRIES(MAX)) u_dut (
      .clk(clk), .rst(rst), .start(start), .rnd(rnd), .ack(ack),
      .target(target), .valid(valid), .busy(busy), .fallback(fallback));

   morse_target_picker #(.NUM_SYMBOLS(16), .MAX_TRIES(8)) u_n16 (
      .clk(clk), .rst(rst), .start(e_start), .rnd(e_rnd), .ack(e_ack),
      .target(t16), .valid(v16), .busy(b16), .fallback(f16));

   morse_target_picker #(.NUM_SYMBOLS(10), .MAX_TRIES(1)) u_m1 (
      .clk(clk), .rst(rst), .start(e_start), .rnd(e_rnd), .ack(e_ack),
      .target(t1), .valid(v1), .busy(b1), .fallback(f1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // request-level model: a request is pending, a target is held, or neither
   bit m_pending = 0;
   bit m_holding = 0;
   int m_tries   = 0;
   int m_tgt     = 0;
   bit m_fb      = 0;
   int m_last    = 0;
   bit m_have    = 0;

   function automatic bit model_ok(int r);
      bit ok;
      ok = (r < NUM);
`ifdef MORSE_NO_REPEAT_EN
      if (m_have && r == m_last) ok = 0;
`endif
      return ok;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pending = 0; m_holding = 0; m_tries = 0;
         m_tgt = 0; m_fb = 0; m_last = 0; m_have = 0;
      end else if (m_holding) begin
         if (ack) begin
            m_holding = 0;
            m_last = m_tgt;
            m_have = 1;
         end
      end else if (m_pending) begin
         m_tries = m_tries + 1;
         if (model_ok(int'(rnd))) begin
            m_tgt = int'(rnd); m_fb = 0; m_holding = 1; m_pending = 0;
         end else if (m_tries >= MAX) begin
            m_tgt = m_have ? (m_last + 1) % NUM : 0;
            m_fb = 1; m_holding = 1; m_pending = 0;
         end
      end else if (start) begin
         m_pending = 1;
         m_tries = 0;
      end
   end

   always @(negedge clk) begin
      n_cmp++;
      if (target !== 4'(m_tgt) || valid !== m_holding ||
          busy !== (m_pending || m_holding) || fallback !== m_fb) begin
         n_err++;
         $display("FAIL model_cycle t=%0t got tgt=%0d v=%0b b=%0b fb=%0b want tgt=%0d v=%0b b=%0b fb=%0b",
                  $time, target, valid, busy, fallback, m_tgt, m_holding,
                  (m_pending || m_holding), m_fb);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input string nm, input int budget);
      int n;
      n = 0;
      while (!valid && n < budget) begin
         step();
         n++;
      end
      n_cmp++;
      if (!valid) begin
         n_err++;
         $display("FAIL %s_timeout got valid=0 want valid=1 after %0d cycles", nm, budget);
      end
   endtask

   task automatic accept(input logic [3:0] v);
      start = 1'b1;
      step();
      start = 1'b0;
      rnd = v;
      wait_valid("accept", 4);
      chk("accept_target", int'(target), int'(v));
      chk("accept_fb", int'(fallback), 0);
   endtask

   task automatic do_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("ack_valid", int'(valid), 0);
      chk("ack_busy", int'(busy), 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; ack = 1'b0; rnd = 4'd0;
      e_start = 1'b0; e_ack = 1'b0; e_rnd = 4'd0;
      repeat (3) step();
      chk("rst_target", int'(target), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_fb", int'(fallback), 0);
      rst = 1'b1;
      step();

      // edge parameters: rnd=11 with no history
      e_start = 1'b1; step(); e_start = 1'b0; e_rnd = 4'd11;
      chk("m1_valid_early", int'(v1), 0);
      chk("m1_busy", int'(b1), 1);
      step();
      chk("n16_tgt11", int'(t16), 11);
      chk("n16_fb0", int'(f16), 0);
      chk("m1_valid", int'(v1), 1);
      chk("m1_tgt0", int'(t1), 0);
      chk("m1_fb1", int'(f1), 1);
      e_ack = 1'b1; step(); e_ack = 1'b0;
      // rnd=15: in range for 16 symbols; fallback to 0+1 for MAX_TRIES=1
      e_start = 1'b1; step(); e_start = 1'b0; e_rnd = 4'd15;
      step();
      chk("n16_tgt15", int'(t16), 15);
      chk("n16_fb15", int'(f16), 0);
      chk("n16_valid", int'(v16), 1);
      chk("m1_tgt_hist", int'(t1), 1);
      chk("m1_fb_hist", int'(f1), 1);
      e_ack = 1'b1; step(); e_ack = 1'b0;

      // immediate accept, valid two edges after start
      start = 1'b1; rnd = 4'd12; step();
      start = 1'b0; rnd = 4'd3;
      chk("imm_busy", int'(busy), 1);
      chk("imm_valid_early", int'(valid), 0);
      step();
      chk("imm_valid", int'(valid), 1);
      chk("imm_target", int'(target), 3);
      chk("imm_fb", int'(fallback), 0);
      do_ack();

      // rejection then fallback from last=9, ack pressed during DRAW is ignored
      accept(4'd9);
      do_ack();
      start = 1'b1; step(); start = 1'b0; rnd = 4'd12; ack = 1'b1;
      repeat (7) step();
      chk("rej_valid_7", int'(valid), 0);
      chk("rej_busy_7", int'(busy), 1);
      ack = 1'b0;
      step();
      chk("fb_valid", int'(valid), 1);
      chk("fb_target", int'(target), 0);
      chk("fb_flag", int'(fallback), 1);
      do_ack();

      // hold stability with toggling rnd and start pulses
      accept(4'd4);
      for (int i = 0; i < 6; i++) begin
         rnd = (i % 2 == 0) ? 4'd1 : 4'd14;
         start = (i % 2 == 0);
         step();
         chk("hold_target", int'(target), 4);
         chk("hold_valid", int'(valid), 1);
      end
      start = 1'b1; ack = 1'b1; rnd = 4'd2; step();
      start = 1'b0; ack = 1'b0;
      chk("startack_busy", int'(busy), 0);
      chk("startack_valid", int'(valid), 0);
      step();
      chk("startack_idle", int'(busy), 0);

      // fallback with history: last=4 -> 5
      start = 1'b1; step(); start = 1'b0; rnd = 4'd10;
      repeat (8) step();
      chk("fb_hist_target", int'(target), 5);
      chk("fb_hist_flag", int'(fallback), 1);
      do_ack();

      // previous target 5, rnd 5,5,2
      start = 1'b1; step(); start = 1'b0; rnd = 4'd5;
      step();
`ifdef MORSE_NO_REPEAT_EN
      chk("norep_valid1", int'(valid), 0);
      rnd = 4'd5; step();
      chk("norep_valid2", int'(valid), 0);
      rnd = 4'd2; step();
      chk("norep_target", int'(target), 2);
`else
      chk("rep_valid", int'(valid), 1);
      chk("rep_target", int'(target), 5);
`endif
      chk("rep_fb", int'(fallback), 0);
      do_ack();

      // reset mid-HOLD with target 7
      accept(4'd7);
      rst = 1'b0;
      #1;
      chk("midrst_target", int'(target), 0);
      chk("midrst_valid", int'(valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_fb", int'(fallback), 0);
      step();
      rst = 1'b1;
      step();
      chk("postrst_idle", int'(busy), 0);
      // history cleared: fallback goes to 0, not 8
      start = 1'b1; step(); start = 1'b0; rnd = 4'd15;
      repeat (8) step();
      chk("postrst_fb_target", int'(target), 0);
      chk("postrst_fb_flag", int'(fallback), 1);
      do_ack();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
